// File: rtl/flag_unit.sv
// Z/V/N flag producer for the WISC core.
// Holds the flag register and resolves ID-stage flag hazards.
module flag_unit #(
    parameter bit FWD_EN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_flush,
    input  logic [3:0]  ex_opcode,
    input  logic [15:0] ex_result,
    input  logic        ex_ovf,
    input  logic        hlt,
    input  logic        id_valid,
    input  logic        id_branch,
    input  logic [2:0]  id_cond,
    output logic [2:0]  flags,
    output logic [2:0]  id_flags,
    output logic        flag_stall,
    output logic [15:0] stall_cnt
);

    logic       is_arith;
    logic       is_zonly;
    logic [2:0] mask;
    logic [2:0] comp;
    logic [2:0] nf;
    logic       wr_en;
    logic       haz;

    assign is_arith = (ex_opcode == 4'b0000) |
                      (ex_opcode == 4'b0001);
    assign is_zonly = (ex_opcode == 4'b0010) |
                      (ex_opcode == 4'b0100) |
                      (ex_opcode == 4'b0101) |
                      (ex_opcode == 4'b0110);

    always_comb begin
        mask = 3'b000;
        unique case (1'b1)
            is_arith: mask = 3'b111;
            is_zonly: mask = 3'b001;
            default:  mask = 3'b000;
        endcase
    end

    // bit order {N, V, Z}
    assign comp  = {ex_result[15], ex_ovf, ex_result == 16'h0000};
    assign nf    = (comp & mask) | (flags & ~mask);
    assign wr_en = ex_valid & ~ex_flush & ~hlt & (|mask);

    assign haz = id_valid & id_branch &
                 (id_cond != 3'b111) & wr_en;

    // outputs are forced quiet while reset is held
    always_comb begin
        flag_stall = 1'b0;
        id_flags   = flags;
        if (!rst_n) begin
            flag_stall = 1'b0;
            id_flags   = 3'b000;
        end else if (FWD_EN) begin
            flag_stall = 1'b0;
            id_flags   = wr_en ? nf : flags;
        end else begin
            flag_stall = haz;
            id_flags   = flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 3'b000;
        end else if (wr_en) begin
            flags <= nf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'h0000;
        end else if (flag_stall && !hlt &&
                     stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'h0001;
        end
    end

endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit: stall variant (u0) and
// forwarding variant (u1) share one set of inputs.
module tb_flag_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_flush;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_result;
    logic        ex_ovf;
    logic        hlt;
    logic        id_valid;
    logic        id_branch;
    logic [2:0]  id_cond;

    logic [2:0]  flags0, flags1;
    logic [2:0]  idf0, idf1;
    logic        stall0, stall1;
    logic [15:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flag_unit #(.FWD_EN(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_flush(ex_flush),
        .ex_opcode(ex_opcode), .ex_result(ex_result),
        .ex_ovf(ex_ovf), .hlt(hlt),
        .id_valid(id_valid), .id_branch(id_branch),
        .id_cond(id_cond),
        .flags(flags0), .id_flags(idf0),
        .flag_stall(stall0), .stall_cnt(cnt0)
    );

    flag_unit #(.FWD_EN(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_flush(ex_flush),
        .ex_opcode(ex_opcode), .ex_result(ex_result),
        .ex_ovf(ex_ovf), .hlt(hlt),
        .id_valid(id_valid), .id_branch(id_branch),
        .id_cond(id_cond),
        .flags(flags1), .id_flags(idf1),
        .flag_stall(stall1), .stall_cnt(cnt1)
    );

    task automatic chk(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic ex(input logic v, input logic f,
                      input logic [3:0] op,
                      input logic [15:0] res,
                      input logic ovf);
        ex_valid  = v;
        ex_flush  = f;
        ex_opcode = op;
        ex_result = res;
        ex_ovf    = ovf;
    endtask

    task automatic id(input logic v, input logic b,
                      input logic [2:0] c);
        id_valid  = v;
        id_branch = b;
        id_cond   = c;
    endtask

    task automatic edge_then_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        hlt   = 1'b0;
        ex(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0);
        id(1'b0, 1'b0, 3'b000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_flags", 16'(flags0), 16'h0);
        chk("rst_cnt", cnt0, 16'h0);
        chk("rst_stall", 16'(stall0), 16'h0);

        // ADD 8000 with overflow -> N=1 V=1 Z=0
        @(negedge clk);
        ex(1'b1, 1'b0, 4'b0000, 16'h8000, 1'b1);
        #1;
        chk("add_idf_stall", 16'(idf0), 16'h0);
        chk("add_idf_fwd", 16'(idf1), 16'h6);
        edge_then_settle();
        chk("add_flags", 16'(flags0), 16'h6);

        // XOR 0 -> Z set, V/N retained
        @(negedge clk);
        ex(1'b1, 1'b0, 4'b0010, 16'h0000, 1'b0);
        edge_then_settle();
        chk("xor_flags", 16'(flags0), 16'h7);

        // LW leaves flags alone
        @(negedge clk);
        ex(1'b1, 1'b0, 4'b1000, 16'h1234, 1'b1);
        edge_then_settle();
        chk("lw_flags", 16'(flags0), 16'h7);

        // SUB 0 with conditional branch in ID
        @(negedge clk);
        ex(1'b1, 1'b0, 4'b0001, 16'h0000, 1'b0);
        id(1'b1, 1'b1, 3'b001);
        #1;
        chk("haz_stall", 16'(stall0), 16'h1);
        chk("haz_idf_stall", 16'(idf0), 16'h7);
        chk("fwd_stall", 16'(stall1), 16'h0);
        chk("fwd_idf", 16'(idf1), 16'h1);
        edge_then_settle();
        chk("haz_flags", 16'(flags0), 16'h1);
        chk("haz_cnt", cnt0, 16'h1);
        @(negedge clk);
        ex(1'b0, 1'b0, 4'b0000, 16'h0000, 1'b0);
        #1;
        chk("bubble_stall", 16'(stall0), 16'h0);
        chk("bubble_idf_z", 16'(idf0[0]), 16'h1);
        edge_then_settle();
        chk("bubble_cnt", cnt0, 16'h1);
        chk("fwd_cnt", cnt1, 16'h0);

        // unconditional branch behind ADD
        @(negedge clk);
        ex(1'b1, 1'b0, 4'b0000, 16'h0005, 1'b0);
        id(1'b1, 1'b1, 3'b111);
        #1;
        chk("uncond_stall", 16'(stall0), 16'h0);
        edge_then_settle();
        chk("uncond_flags", 16'(flags0), 16'h0);

        // flush wins over valid
        @(negedge clk);
        ex(1'b1, 1'b1, 4'b0000, 16'h0000, 1'b1);
        id(1'b1, 1'b1, 3'b001);
        #1;
        chk("flush_stall", 16'(stall0), 16'h0);
        chk("flush_idf_fwd", 16'(idf1), 16'h0);
        edge_then_settle();
        chk("flush_flags", 16'(flags0), 16'h0);

        // halt freezes everything
        @(negedge clk);
        hlt = 1'b1;
        ex(1'b1, 1'b0, 4'b0000, 16'h0000, 1'b1);
        id(1'b1, 1'b1, 3'b000);
        #1;
        chk("hlt_stall", 16'(stall0), 16'h0);
        edge_then_settle();
        chk("hlt_flags", 16'(flags0), 16'h0);
        chk("hlt_cnt", cnt0, 16'h1);

        // set flags nonzero, then reset mid-stall
        @(negedge clk);
        hlt = 1'b0;
        ex(1'b1, 1'b0, 4'b0000, 16'h8000, 1'b1);
        id(1'b0, 1'b0, 3'b000);
        edge_then_settle();
        chk("pre_rst_flags", 16'(flags0), 16'h6);
        @(negedge clk);
        ex(1'b1, 1'b0, 4'b0000, 16'h0000, 1'b0);
        id(1'b1, 1'b1, 3'b001);
        #1;
        chk("pre_rst_stall", 16'(stall0), 16'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_flags", 16'(flags0), 16'h0);
        chk("mid_rst_cnt", cnt0, 16'h0);
        chk("mid_rst_stall", 16'(stall0), 16'h0);
        chk("mid_rst_idf_fwd", 16'(idf1), 16'h0);
        edge_then_settle();
        chk("rst_edge_flags", 16'(flags0), 16'h0);
        chk("rst_edge_cnt", cnt0, 16'h0);

        // continuous hazard until the counter saturates
        @(negedge clk);
        rst_n = 1'b1;
        ex(1'b1, 1'b0, 4'b0000, 16'h0001, 1'b0);
        id(1'b1, 1'b1, 3'b001);
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", cnt0, 16'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_ffff", cnt0, 16'hFFFF);
        chk("sat_fwd_cnt", cnt1, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("sat_hold", cnt0, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/flag_unit.md
# flag_unit

Producer side of the branch-condition flag interface for the pipelined WISC core. The block computes Z/V/N from EX-stage ALU results, holds them in the architectural flag register, and delivers them to ID-stage branch resolution. When an ID-stage branch depends on flags still being produced in EX, it either stalls the branch or forwards the flags. It also counts flag-hazard stall cycles for performance analysis.

## Interface
- FWD_EN, 0, 0: stall ID one cycle on a flag hazard; 1: forward next-flag value to ID, never stall
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX stage holds a real instruction
- ex_flush  in  1  kill the EX instruction; no flag update
- ex_opcode  in  4  EX instruction opcode
- ex_result  in  16  ALU result after saturation
- ex_ovf  in  1  ALU signed overflow, meaningful for ADD/SUB only
- hlt  in  1  core halted; freeze all state
- id_valid  in  1  ID stage holds a real instruction
- id_branch  in  1  ID instruction is B or BR
- id_cond  in  3  branch condition field of the ID instruction
- flags  out  3  architectural flag register: [0]=Z, [1]=V, [2]=N
- id_flags  out  3  flags the ID-stage branch must evaluate, same bit order
- flag_stall  out  1  hold PC/IF/ID and bubble EX this cycle
- stall_cnt  out  16  count of cycles with flag_stall high

## Operation
- Flag-writing opcodes (wr_en = ex_valid & ~ex_flush & ~hlt & writer):
  - 0000 ADD, 0001 SUB: write Z, V, N.
  - 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR: write Z only. V and N are retained.
  - All other opcodes leave flags unchanged.
- Computed values:
  - Z = (ex_result == 16'h0000).
  - N = ex_result[15].
  - V = ex_ovf.
- Next-flag value nf: per-bit mux of the computed value and the current `flags`, selected by the per-opcode write mask.
- Hazard: haz = id_valid & id_branch & (id_cond != 3'b111) & wr_en.
  - Unconditional branches never cause a hazard.
- FWD_EN=0:
  - flag_stall = haz. id_flags = flags.
  - The stalled branch is re-presented the next cycle and sees the updated register.
- FWD_EN=1:
  - flag_stall = 0. id_flags = nf when wr_en, otherwise flags.
- stall_cnt:
  - Increments on each clock edge where flag_stall=1 and hlt=0.
  - Saturates at 16'hFFFF.
- hlt=1:
  - flags and stall_cnt hold.
  - wr_en=0, so flag_stall=0.
- ex_flush and ex_valid both high: flush wins, no update.

## Timing
- Reset (rst_n=0, asynchronous): flags=3'b000, stall_cnt=16'h0000.
  - With reset asserted, flag_stall=0 and id_flags=3'b000 regardless of other inputs.
- Reset mid-stall clears the counter immediately. Flags written in that cycle are lost.
- Flag update latency: one edge. nf is written at the edge ending the EX cycle and is visible on `flags` the following cycle.
- flag_stall and id_flags are combinational from the current inputs and state; there are no internal registers on them.
- A stall lasts exactly one cycle per hazard:
  - The next cycle, EX holds a bubble (ex_valid=0), so the hazard clears.
  - Back-to-back writers followed by a branch stall only against the writer currently in EX.
- Writer in EX with a non-branch in ID: no stall. Register updates normally.

## Test plan
- Reset values:
  - Drive rst_n=0 mid-cycle with ADD result 0 in EX.
  - Required: flags=000 and stall_cnt=0 immediately; no update at the next edge.
- Write masks:
  - Drive ADD, result 16'h8000, ex_ovf=1. Required next cycle: flags=3'b110.
  - Then drive XOR, result 16'h0000. Required next cycle: flags=3'b111 (Z set, V/N retained).
  - Then drive LW. Required: flags unchanged.
- Stall path (FWD_EN=0):
  - Drive SUB, result 0, in EX and a B with cond 001 in ID.
  - Required: flag_stall=1 for exactly one cycle. Next cycle: id_flags[0]=1 and stall_cnt=1.
- Forward path (FWD_EN=1):
  - Same stimulus as the stall path.
  - Required: flag_stall=0 and id_flags=3'b001 in the same cycle.
- Exemptions:
  - Unconditional branch (cond 111) behind an ADD: no stall.
  - ex_flush=1 with ex_valid=1 on an ADD: flags unchanged, no stall.
  - hlt=1: flags and stall_cnt frozen.
- Saturation:
  - Preload stall_cnt=16'hFFFE, then drive three consecutive hazard cycles.
  - Required: stall_cnt=16'hFFFF and held.
